// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: LSU request/response front end for a word-organised byte-enable data RAM
// Ports: i_clk/i_rst (async active-low); request i_req_valid/o_req_ready with
// i_req_wren, i_req_addr, i_req_data, i_req_funct3; response o_rsp_valid/i_rsp_ready
// with o_rsp_data (extended load result, 0 for stores/errors) and o_rsp_err.
module lsu_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wren,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_data,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err
);
    localparam int WORDS = 1 << (ADDR_W - 2);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       mem [WORDS];
    logic [31:0]       ram_rdata;
    logic              accept, err, we;
    logic [1:0]        lo;
    logic [3:0]        be;
    logic [31:0]       wdata, ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_addr;
    assign o_req_ready = state_q == IDLE;
    assign o_rsp_valid = state_q == RESP;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign accept      = i_req_valid && o_req_ready;
    assign unused_addr = ^i_req_addr[31:ADDR_W];
    always_comb begin
        lo      = addr_q[1:0];
        err     = funct3_q == 3'b011 || funct3_q[2:1] == 2'b11 || (wren_q && funct3_q[2])
                  || (funct3_q[1:0] == 2'b01 && lo[0]) || (funct3_q[1:0] == 2'b10 && lo != 2'b00);
        be      = funct3_q[1:0] == 2'b00 ? 4'b0001 << lo :
                  funct3_q[1:0] == 2'b01 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = funct3_q[1:0] == 2'b00 ? {4{data_q[7:0]}} :
                  funct3_q[1:0] == 2'b01 ? {2{data_q[15:0]}} : data_q;
        we      = state_q == ACCESS && wren_q && !err;
        ld_byte = 8'(ram_rdata >> {lo, 3'b000});
        ld_half = lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        // funct3[2] marks the unsigned variants, which suppress sign extension
        ld_data = funct3_q[1:0] == 2'b00 ? {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte} :
                  funct3_q[1:0] == 2'b01 ? {{16{ld_half[15] & ~funct3_q[2]}}, ld_half} : ram_rdata;
    end
    always_comb begin
        state_d    = state_q;
        wren_d     = wren_q;
        addr_d     = addr_q;
        data_d     = data_q;
        funct3_d   = funct3_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                wren_d   = i_req_wren;
                addr_d   = i_req_addr[ADDR_W-1:0];
                data_d   = i_req_data;
                funct3_d = i_req_funct3;
                state_d  = ACCESS;
            end
            ACCESS: begin
                rsp_err_d  = err;
                rsp_data_d = (err || wren_q) ? 32'd0 : ld_data;
                state_d    = RESP;
            end
            RESP: state_d = i_rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            funct3_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            funct3_q   <= funct3_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
    // RAM is read at the accepting edge so the word is ready for formatting in ACCESS;
    // writes land at E1 only when the FSM is still in ACCESS, so a reset before E1 drops them.
    always_ff @(posedge i_clk) begin
        if (accept)
            ram_rdata <= mem[i_req_addr[ADDR_W-1:2]];
        for (int i = 0; i < 4; i++)
            if (we && be[i])
                mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb_lsu_mem_responder: directed self-checking bench for lsu_mem_responder
module tb_lsu_mem_responder;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wren = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_ready = 1'b0;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_data;
    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_responder #(.ADDR_W(10)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_req_wren(req_wren), .i_req_addr(req_addr), .i_req_data(req_data),
        .i_req_funct3(req_funct3),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drive a request, wait for its accepting edge, then scramble the inputs to prove they are not resampled.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int n = 0;
        @(negedge i_clk);
        req_wren = w; req_addr = a; req_data = d; req_funct3 = f; req_valid = 1'b1;
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge i_clk);
        #1;
        req_valid = 1'b0; req_wren = 1'b1; req_addr = 32'h10; req_data = 32'h0; req_funct3 = 3'b010;
        check("ready_after_e0", 32'(o_req_ready), 32'd0);
        check("valid_after_e0", 32'(o_rsp_valid), 32'd0);
    endtask

    task automatic resp(input string tag, input logic [31:0] ed, input logic ee);
        @(posedge i_clk);
        #1;
        check({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_data"}, o_rsp_data, ed);
        check({tag, "_err"}, 32'(o_rsp_err), 32'(ee));
        @(negedge i_clk);
        rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_req_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic [31:0] ed, input logic ee);
        send(w, a, d, f);
        resp(tag, ed, ee);
    endtask

    initial begin
        #12;
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_data", o_rsp_data, 32'd0);
        check("rst_err", 32'(o_rsp_err), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;

        xact("sw_word", 1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        xact("lw_word", 0, 32'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        xact("sb_13", 1, 32'h013, 32'h00000080, 3'b000, 32'h0, 0);
        xact("lb_13", 0, 32'h013, 32'h0, 3'b000, 32'hFFFFFF80, 0);
        xact("lbu_13", 0, 32'h013, 32'h0, 3'b100, 32'h00000080, 0);
        xact("lw_after_sb", 0, 32'h010, 32'h0, 3'b010, 32'h80ADBEEF, 0);
        xact("sh_12", 1, 32'h012, 32'h00001234, 3'b001, 32'h0, 0);
        xact("lhu_12", 0, 32'h012, 32'h0, 3'b101, 32'h00001234, 0);
        xact("lw_after_sh", 0, 32'h010, 32'h0, 3'b010, 32'h1234BEEF, 0);
        xact("lb_10", 0, 32'h010, 32'h0, 3'b000, 32'hFFFFFFEF, 0);
        xact("lh_10", 0, 32'h010, 32'h0, 3'b001, 32'hFFFFBEEF, 0);
        xact("lhu_10", 0, 32'h010, 32'h0, 3'b101, 32'h0000BEEF, 0);
        xact("lbu_11", 0, 32'h011, 32'h0, 3'b100, 32'h000000BE, 0);

        xact("lh_mis", 0, 32'h011, 32'h0, 3'b001, 32'h0, 1);
        xact("sw_mis", 1, 32'h012, 32'hFFFFFFFF, 3'b010, 32'h0, 1);
        xact("lw_unchanged", 0, 32'h010, 32'h0, 3'b010, 32'h1234BEEF, 0);
        xact("f3_011", 0, 32'h010, 32'h0, 3'b011, 32'h0, 1);
        xact("f3_110", 0, 32'h010, 32'h0, 3'b110, 32'h0, 1);
        xact("sbu_err", 1, 32'h010, 32'h0, 3'b100, 32'h0, 1);
        xact("lw_unchanged2", 0, 32'h010, 32'h0, 3'b010, 32'h1234BEEF, 0);

        send(0, 32'h010, 32'h0, 3'b010);
        @(posedge i_clk);
        #1;
        check("bp_valid", 32'(o_rsp_valid), 32'd1);
        @(negedge i_clk);
        req_wren = 1'b0; req_addr = 32'h010; req_funct3 = 3'b100; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check("bp_data", o_rsp_data, 32'h1234BEEF);
            check("bp_err", 32'(o_rsp_err), 32'd0);
            check("bp_ready", 32'(o_req_ready), 32'd0);
            check("bp_hold", 32'(o_rsp_valid), 32'd1);
        end
        @(negedge i_clk);
        rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_consumed", 32'(o_rsp_valid), 32'd0);
        check("bp_no_reaccept", 32'(o_req_ready), 32'd1);
        @(posedge i_clk);
        #1;
        req_valid = 1'b0;
        check("bp_accept_late", 32'(o_req_ready), 32'd0);
        resp("bp_lbu", 32'h000000EF, 0);

        xact("sw_alias", 1, 32'h410, 32'hCAFEF00D, 3'b010, 32'h0, 0);
        xact("lw_alias", 0, 32'h010, 32'h0, 3'b010, 32'hCAFEF00D, 0);

        xact("sw_20", 1, 32'h020, 32'h5A5A5A5A, 3'b010, 32'h0, 0);
        send(1, 32'h020, 32'h11111111, 3'b010);
        i_rst = 1'b0;
        #1;
        check("rst_access_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        xact("lw_20_kept", 0, 32'h020, 32'h0, 3'b010, 32'h5A5A5A5A, 0);

        send(0, 32'h011, 32'h0, 3'b001);
        @(posedge i_clk);
        #1;
        check("rst_resp_pre_err", 32'(o_rsp_err), 32'd1);
        #2;
        i_rst = 1'b0;
        #1;
        check("rst_resp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_resp_err", 32'(o_rsp_err), 32'd0);
        check("rst_resp_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;

        send(0, 32'h010, 32'h0, 3'b010);
        @(posedge i_clk);
        #1;
        check("rst_resp_pre_data", o_rsp_data, 32'hCAFEF00D);
        #2;
        i_rst = 1'b0;
        #1;
        check("rst_resp_valid2", 32'(o_rsp_valid), 32'd0);
        check("rst_resp_data", o_rsp_data, 32'd0);
        check("rst_resp_ready2", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        xact("lw_after_rst", 0, 32'h010, 32'h0, 3'b010, 32'hCAFEF00D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
